dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's MEM stage data port; produces the data_ready_mem stall signal consumed by the pipeline registers.
- Accepts the core's MEM-stage read and write requests: read/write strobes, byte address and store data.
- Reads from a synchronous block RAM with configurable read latency; holds the pipeline frozen until read data is registered.
- Writes are posted in a single cycle with no stall; address checks raise sticky error flags.

Parameters:
- ADDR_WIDTH, 12, word-address width; memory depth = 2**ADDR_WIDTH words.
- READ_LATENCY, 2, cycles from mem_en sampled to mem_rdata valid; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  synchronous active-low reset.
- memread_mem  in  1  core read request, level, held stable while stalled.
- memwrite_mem  in  1  core write request, level.
- alu_result_mem  in  32  byte address.
- write_data_memory_mem  in  32  store data.
- data_ready_mem  out  1  1 = pipeline may advance; 0 = stall.
- data_from_memory_mem  out  32  registered read data.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_WIDTH  BRAM word address.
- mem_wdata  out  32  BRAM write data.
- mem_rdata  in  32  BRAM read data.
- misaligned_err  out  1  sticky; set when any accepted request has addr[1:0] != 0.
- range_err  out  1  sticky; set when any accepted request has addr >= 4*2**ADDR_WIDTH.

Behaviour:
- Reset values: state IDLE, counter 0, data_from_memory_mem 0, misaligned_err 0, range_err 0.
  - Outputs data_ready_mem=1, mem_en=0, mem_we=0.
  - Reset mid-read aborts the access; an in-flight mem_rdata is ignored.
- Address mapping:
  - mem_addr = alu_result_mem[ADDR_WIDTH+1:2] (low two bits dropped; misaligned accesses use the aligned word).
  - Driven combinationally from alu_result_mem in every state.
- In-range test: alu_result_mem[31:ADDR_WIDTH+2] == 0.
- States IDLE, BUSY, DONE:
  - IDLE, memread_mem=1:
    - Drive mem_en=1 combinationally and data_ready_mem=0 combinationally in the same cycle.
    - Load counter=1 and go to BUSY.
    - Update error flags.
  - IDLE, memwrite_mem=1 and memread_mem=0:
    - In range: mem_en=1, mem_we=1, mem_wdata=write_data_memory_mem.
    - Out of range: write suppressed (mem_we=0).
    - data_ready_mem stays 1; state stays IDLE. Zero-stall posted write.
    - Update error flags.
  - IDLE, no request: data_ready_mem=1; data_from_memory_mem holds its value.
  - BUSY:
    - data_ready_mem=0, mem_en=0.
    - If counter==READ_LATENCY: capture into data_from_memory_mem (mem_rdata if in range, else 32'h0) and go to DONE.
    - Otherwise increment counter.
  - DONE:
    - data_ready_mem=1; data_from_memory_mem valid for the core's MEM/WB capture at this edge.
    - Next state IDLE unconditionally. The DONE cycle never re-issues the still-present request.
- Read stall length: data_ready_mem low for READ_LATENCY+1 cycles per read, then high for one DONE cycle.
- Back-to-back reads: the next request is seen in the IDLE cycle after DONE.
- memread_mem and memwrite_mem both 1: treat as read only; write suppressed; no error flag.
- Error flags are sticky until reset and are updated only in IDLE when a request is accepted.
- The block assumes request inputs are stable while data_ready_mem=0; it does not re-sample them in BUSY.

Test Plan:
- Reset: rstn=0 for 2 cycles during an active read -> data_ready_mem=1, state IDLE, data_from_memory_mem=0, both error flags 0, mem_en=0 next cycle.
- Read, READ_LATENCY=2, BRAM word 5 = 32'hDEADBEEF, memread_mem=1, addr=32'h14:
  - mem_en=1 and mem_addr=5 in cycle 0.
  - data_ready_mem=0 in cycles 0-2, 1 in cycle 3 with data_from_memory_mem=32'hDEADBEEF.
- Write, addr=32'h20, data=32'h12345678:
  - Same cycle: mem_we=1, mem_addr=8, data_ready_mem stays 1.
  - A following read of 32'h20 returns 32'h12345678.
- Back-to-back reads of addr 0 then 4, READ_LATENCY=1: two 3-cycle windows (low, low, high) separated by one IDLE issue cycle, returning the correct words in order.
- Errors:
  - Read at 32'h7 -> misaligned_err=1, word 1 returned.
  - Write at 32'h4000 with ADDR_WIDTH=12 -> range_err=1, mem_we=0, no stall.
  - Read at 32'h4000 -> returns 0 after the full latency.
- memread_mem=memwrite_mem=1 at addr 32'h8 -> read performed, mem_we=0 throughout, BRAM word 2 unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// MEM-stage data port responder: posted single-cycle writes and stalling reads
// against a synchronous block RAM whose read latency is set by READ_LATENCY.
module dmem_responder #(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  memread_mem,
  input  logic                  memwrite_mem,
  input  logic [31:0]           alu_result_mem,
  input  logic [31:0]           write_data_memory_mem,
  output logic                  data_ready_mem,
  output logic [31:0]           data_from_memory_mem,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  misaligned_err,
  output logic                  range_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] LAST_COUNT = 3'(READ_LATENCY);

  logic [1:0]  state_reg, state_next;
  logic [2:0]  count_reg, count_next;
  logic        in_range_reg, in_range_next;
  logic [31:0] data_reg, data_next;
  logic        misaligned_reg, misaligned_next;
  logic        range_reg, range_next;

  logic        in_range;
  logic        misaligned;
  logic        ready_c;
  logic        en_c;
  logic        we_c;

  generate
    if (ADDR_WIDTH + 2 < 32) begin : g_range
      assign in_range = (alu_result_mem[31:ADDR_WIDTH+2] == '0);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  assign misaligned = |alu_result_mem[1:0];

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    in_range_next   = in_range_reg;
    data_next       = data_reg;
    misaligned_next = misaligned_reg;
    range_next      = range_reg;
    ready_c         = 1'b1;
    en_c            = 1'b0;
    we_c            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (memread_mem) begin
          // A simultaneous write request is dropped: the read wins.
          en_c            = 1'b1;
          ready_c         = 1'b0;
          count_next      = 3'd1;
          in_range_next   = in_range;
          state_next      = BUSY;
          misaligned_next = misaligned_reg | misaligned;
          range_next      = range_reg | ~in_range;
        end else if (memwrite_mem) begin
          en_c            = in_range;
          we_c            = in_range;
          misaligned_next = misaligned_reg | misaligned;
          range_next      = range_reg | ~in_range;
        end
      end
      BUSY: begin
        ready_c = 1'b0;
        if (count_reg == LAST_COUNT) begin
          data_next  = in_range_reg ? mem_rdata : 32'h0;
          state_next = DONE;
        end else begin
          count_next = count_reg + 3'd1;
        end
      end
      DONE: begin
        // Request is still asserted here; returning to IDLE first avoids a re-issue.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      count_reg      <= 3'd0;
      in_range_reg   <= 1'b0;
      data_reg       <= 32'h0;
      misaligned_reg <= 1'b0;
      range_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      in_range_reg   <= in_range_next;
      data_reg       <= data_next;
      misaligned_reg <= misaligned_next;
      range_reg      <= range_next;
    end
  end

  // Held in reset, the port neither stalls the core nor touches the RAM.
  assign data_ready_mem       = ready_c | ~rstn;
  assign mem_en               = en_c & rstn;
  assign mem_we               = we_c & rstn;
  assign mem_addr             = alu_result_mem[ADDR_WIDTH+1:2];
  assign mem_wdata            = write_data_memory_mem;
  assign data_from_memory_mem = data_reg;
  assign misaligned_err       = misaligned_reg;
  assign range_err            = range_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: BRAM model, transaction-level reference model with
// a per-cycle compare, randomized traffic and a few hand-computed expectations.
module tb_dmem_responder;

  localparam int AW    = 12;
  localparam int RL    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          memread = 1'b0;
  logic          memwrite = 1'b0;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic          data_ready_mem;
  logic [31:0]   data_from_memory_mem;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          misaligned_err;
  logic          range_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .memread_mem           (memread),
    .memwrite_mem          (memwrite),
    .alu_result_mem        (addr),
    .write_data_memory_mem (wdata),
    .data_ready_mem        (data_ready_mem),
    .data_from_memory_mem  (data_from_memory_mem),
    .mem_en                (mem_en),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .mem_rdata             (mem_rdata),
    .misaligned_err        (misaligned_err),
    .range_err             (range_err)
  );

  // Synchronous BRAM: address sampled with mem_en, data out RL-1 registers later.
  logic [31:0] bram [DEPTH];
  logic [31:0] rpipe [RL];

  always @(posedge clk) begin
    if (mem_en && mem_we) bram[mem_addr] <= mem_wdata;
    if (mem_en) rpipe[0] <= bram[mem_addr];
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a read owns the port for RL+1 stalled cycles, then one
  // ready cycle with the word it read; writes update the model memory at once.
  logic [31:0] exp_mem [DEPTH];
  int          busy_left = 0;
  bit          done_pending = 0;
  bit          synced = 0;
  logic [31:0] exp_dout = 32'h0;
  logic [31:0] rd_val = 32'h0;
  bit          exp_mis = 0;
  bit          exp_rng = 0;
  bit          m_inr;
  bit          m_mis;
  logic [AW-1:0] m_word;

  always @(negedge clk) begin
    m_inr  = (addr[31:AW+2] == '0);
    m_mis  = |addr[1:0];
    m_word = addr[AW+1:2];
    check("mem_addr", 32'(mem_addr), 32'(m_word));
    if (!rstn) begin
      check("rst_ready", 32'(data_ready_mem), 32'd1);
      check("rst_en", 32'(mem_en), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      busy_left    = 0;
      done_pending = 0;
      exp_dout     = 32'h0;
      exp_mis      = 0;
      exp_rng      = 0;
      synced       = 1;
    end else begin
      if (synced) begin
        check("dout", data_from_memory_mem, exp_dout);
        check("misaligned_err", 32'(misaligned_err), 32'(exp_mis));
        check("range_err", 32'(range_err), 32'(exp_rng));
      end
      if (done_pending) begin
        check("done_ready", 32'(data_ready_mem), 32'd1);
        check("done_en", 32'(mem_en), 32'd0);
        check("done_we", 32'(mem_we), 32'd0);
        done_pending = 0;
      end else if (busy_left > 0) begin
        check("busy_ready", 32'(data_ready_mem), 32'd0);
        check("busy_en", 32'(mem_en), 32'd0);
        check("busy_we", 32'(mem_we), 32'd0);
        busy_left--;
        if (busy_left == 0) begin
          exp_dout     = rd_val;
          done_pending = 1;
        end
      end else if (memread) begin
        check("issue_ready", 32'(data_ready_mem), 32'd0);
        check("issue_en", 32'(mem_en), 32'd1);
        check("issue_we", 32'(mem_we), 32'd0);
        busy_left = RL;
        rd_val    = m_inr ? exp_mem[m_word] : 32'h0;
        exp_mis   = exp_mis | m_mis;
        exp_rng   = exp_rng | !m_inr;
      end else if (memwrite) begin
        check("wr_ready", 32'(data_ready_mem), 32'd1);
        check("wr_en", 32'(mem_en), 32'(m_inr));
        check("wr_we", 32'(mem_we), 32'(m_inr));
        if (m_inr) begin
          check("wr_data", mem_wdata, wdata);
          exp_mem[m_word] = wdata;
        end
        exp_mis = exp_mis | m_mis;
        exp_rng = exp_rng | !m_inr;
      end else begin
        check("idle_ready", 32'(data_ready_mem), 32'd1);
        check("idle_en", 32'(mem_en), 32'd0);
        check("idle_we", 32'(mem_we), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    memread = 1'b1;
    addr    = a;
    n       = 0;
    do begin
      @(negedge clk);
      n++;
    end while (data_ready_mem !== 1'b1 && n < 20);
    check("read_done", 32'(data_ready_mem), 32'd1);
    check("read_cycles", 32'(n), 32'(RL + 2));
    d = data_from_memory_mem;
    step();
    memread = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] v);
    memwrite = 1'b1;
    addr     = a;
    wdata    = v;
    step();
    memwrite = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input bit allow_err);
    logic [31:0] a;
    int r;
    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    if (allow_err) begin
      r = $urandom_range(0, 7);
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) begin
        a = $urandom;
        if (a[31:AW+2] == '0) a = a | 32'h4000;
      end
    end
    return a;
  endfunction

  task automatic random_phase(input int count, input bit allow_err);
    logic [31:0] d;
    for (int t = 0; t < count; t++) begin
      case ($urandom_range(0, 4))
        0, 1: do_read(rand_addr(allow_err), d);
        2:    do_write(rand_addr(allow_err), $urandom);
        3: begin
          memwrite = 1'b1;
          wdata    = $urandom;
          do_read(rand_addr(allow_err), d);
          memwrite = 1'b0;
        end
        default: step();
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      bram[i]    = $urandom;
      exp_mem[i] = bram[i];
    end
    for (int i = 0; i < RL; i++) rpipe[i] = 32'h0;
    bram[0] = 32'hC0DE_0000;  exp_mem[0] = 32'hC0DE_0000;
    bram[1] = 32'h1111_0001;  exp_mem[1] = 32'h1111_0001;
    bram[2] = 32'hA5A5_0002;  exp_mem[2] = 32'hA5A5_0002;
    bram[5] = 32'hDEAD_BEEF;  exp_mem[5] = 32'hDEAD_BEEF;

    rstn = 1'b0;
    step(); step(); step();
    rstn = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(data_ready_mem), 32'd1);
    check("reset_dout", data_from_memory_mem, 32'h0);
    check("reset_mis", 32'(misaligned_err), 32'd0);
    check("reset_rng", 32'(range_err), 32'd0);
    check("reset_en", 32'(mem_en), 32'd0);
    step();

    // Read word 5: stalled for cycles 0..2, ready with data in cycle 3.
    memread = 1'b1;
    addr    = 32'h14;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("rd14_en", 32'(mem_en), 32'd1);
        check("rd14_addr", 32'(mem_addr), 32'd5);
      end
      check("rd14_ready", 32'(data_ready_mem), (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) check("rd14_data", data_from_memory_mem, 32'hDEAD_BEEF);
    end
    step();
    memread = 1'b0;

    memwrite = 1'b1;
    addr     = 32'h20;
    wdata    = 32'h1234_5678;
    @(negedge clk);
    check("wr20_we", 32'(mem_we), 32'd1);
    check("wr20_addr", 32'(mem_addr), 32'd8);
    check("wr20_ready", 32'(data_ready_mem), 32'd1);
    step();
    memwrite = 1'b0;
    do_read(32'h20, d);
    check("rd20_data", d, 32'h1234_5678);

    do_read(32'h0, d);
    check("b2b_word0", d, 32'hC0DE_0000);
    do_read(32'h4, d);
    check("b2b_word1", d, 32'h1111_0001);

    // Read and write together: only the read happens.
    memread  = 1'b1;
    memwrite = 1'b1;
    addr     = 32'h8;
    wdata    = 32'hFFFF_FFFF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      check("both_we", 32'(mem_we), 32'd0);
    end while (data_ready_mem !== 1'b1 && n < 20);
    check("both_data", data_from_memory_mem, 32'hA5A5_0002);
    step();
    memread  = 1'b0;
    memwrite = 1'b0;
    do_read(32'h8, d);
    check("both_word2_kept", d, 32'hA5A5_0002);

    random_phase(200, 1'b0);

    do_read(32'h7, d);
    check("mis_data", d, 32'h1111_0001);
    @(negedge clk);
    check("mis_flag", 32'(misaligned_err), 32'd1);
    check("mis_rng_clear", 32'(range_err), 32'd0);
    step();
    memwrite = 1'b1;
    addr     = 32'h4000;
    wdata    = 32'h5555_AAAA;
    @(negedge clk);
    check("oor_wr_we", 32'(mem_we), 32'd0);
    check("oor_wr_ready", 32'(data_ready_mem), 32'd1);
    step();
    memwrite = 1'b0;
    @(negedge clk);
    check("oor_rng_flag", 32'(range_err), 32'd1);
    step();
    do_read(32'h4000, d);
    check("oor_rd_zero", d, 32'h0);

    // Reset in the middle of a read clears everything and drops the access.
    memread = 1'b1;
    addr    = 32'h14;
    step();
    rstn = 1'b0;
    step();
    @(negedge clk);
    check("midrst_ready", 32'(data_ready_mem), 32'd1);
    check("midrst_dout", data_from_memory_mem, 32'h0);
    check("midrst_mis", 32'(misaligned_err), 32'd0);
    check("midrst_rng", 32'(range_err), 32'd0);
    step();
    memread = 1'b0;
    rstn    = 1'b1;
    @(negedge clk);
    check("postrst_en", 32'(mem_en), 32'd0);
    check("postrst_ready", 32'(data_ready_mem), 32'd1);
    check("postrst_dout", data_from_memory_mem, 32'h0);
    step();

    random_phase(150, 1'b1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
